// File: rtl/fetch_pkg.sv
// Shared front-end definitions: fetch FSM encoding, instruction field
// positions and the jump opcodes that decode and the hazard unit also use.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_KILL  = 2'd3
   } fetch_state_e;

   localparam int OPCODE_HI = 15;
   localparam int OPCODE_LO = 12;
   localparam int RD_HI     = 11;
   localparam int RD_LO     = 8;
   localparam int RS1_HI    = 7;
   localparam int RS1_LO    = 4;
   localparam int RS2_HI    = 3;
   localparam int RS2_LO    = 0;

   localparam logic [3:0] OPC_JMP_A = 4'b0100;
   localparam logic [3:0] OPC_JMP_B = 4'b0110;

   function automatic logic is_jump(input logic [3:0] opc);
      return (opc == OPC_JMP_A) || (opc == OPC_JMP_B);
   endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Single-entry {pc, inst} holding register that parks a fetched
// instruction while decode is stalled.
module fetch_skid_buffer #(
   parameter int PC_WIDTH   = 16,
   parameter int INST_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic                  drain,
   input  logic                  clear,
   input  logic [PC_WIDTH-1:0]   pc_in,
   input  logic [INST_WIDTH-1:0] inst_in,
   output logic                  valid,
   output logic [PC_WIDTH-1:0]   pc,
   output logic [INST_WIDTH-1:0] inst
);

   logic                  valid_q, valid_d;
   logic [PC_WIDTH-1:0]   pc_q, pc_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;

   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      if (clear) begin
         valid_d = 1'b0;
         pc_d    = '0;
         inst_d  = '0;
      end else if (load) begin
         valid_d = 1'b1;
         pc_d    = pc_in;
         inst_d  = inst_in;
      end else if (drain) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         inst_q  <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
      end
   end

   assign valid = valid_q;
   assign pc    = pc_q;
   assign inst  = inst_q;

endmodule

// File: rtl/fetch_stage_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem request port and
// holds the IF/ID register with stall, flush and redirect handling.
module fetch_stage_unit
   import fetch_pkg::*;
#(
   parameter int                   PC_WIDTH   = 16,
   parameter int                   INST_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  stall_n,
   input  logic                  branch_taken,
   input  logic [PC_WIDTH-1:0]   branch_target,
   output logic                  imem_req,
   output logic [PC_WIDTH-1:0]   imem_addr,
   input  logic [INST_WIDTH-1:0] imem_rdata,
   input  logic                  imem_ready,
   output logic                  ifid_valid,
   output logic [PC_WIDTH-1:0]   ifid_pc,
   output logic [INST_WIDTH-1:0] ifid_inst,
   output logic [3:0]            ifid_opcode,
   output logic [3:0]            ifid_rd,
   output logic [3:0]            ifid_rs1,
   output logic [3:0]            ifid_rs2
);

   fetch_state_e          state_q, state_d;
   logic [PC_WIDTH-1:0]   pc_q, pc_d;
   logic [PC_WIDTH-1:0]   tgt_q, tgt_d;
   logic                  req_q, req_d;
   logic                  valid_q, valid_d;
   logic [PC_WIDTH-1:0]   ipc_q, ipc_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;

   logic                  sk_load, sk_drain, sk_clear;
   logic                  sk_valid;
   logic [PC_WIDTH-1:0]   sk_pc;
   logic [INST_WIDTH-1:0] sk_inst;

   logic                  new_v;
   logic [PC_WIDTH-1:0]   new_pc;
   logic [INST_WIDTH-1:0] new_inst;
   logic [PC_WIDTH-1:0]   pc_inc;

   assign pc_inc = pc_q + PC_WIDTH'(1);

   fetch_skid_buffer #(
      .PC_WIDTH   (PC_WIDTH),
      .INST_WIDTH (INST_WIDTH)
   ) u_skid (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (sk_load),
      .drain   (sk_drain),
      .clear   (sk_clear),
      .pc_in   (pc_q),
      .inst_in (imem_rdata),
      .valid   (sk_valid),
      .pc      (sk_pc),
      .inst    (sk_inst)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      tgt_d    = tgt_q;
      valid_d  = valid_q;
      ipc_d    = ipc_q;
      inst_d   = inst_q;
      sk_load  = 1'b0;
      sk_drain = 1'b0;
      sk_clear = 1'b0;
      new_v    = 1'b0;
      new_pc   = '0;
      new_inst = '0;

      unique case (state_q)
         ST_BOOT: state_d = ST_FETCH;
         ST_FETCH: begin
            if (branch_taken) begin
               if (imem_ready) begin
                  pc_d = branch_target;
               end else begin
                  tgt_d   = branch_target;
                  state_d = ST_KILL;
               end
            end else if (imem_ready) begin
               pc_d = pc_inc;
               if (stall_n) begin
                  new_v    = 1'b1;
                  new_pc   = pc_q;
                  new_inst = imem_rdata;
               end else begin
                  sk_load = 1'b1;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (branch_taken) begin
               sk_clear = 1'b1;
               pc_d     = branch_target;
               state_d  = ST_FETCH;
            end else if (stall_n) begin
               sk_drain = 1'b1;
               new_v    = sk_valid;
               new_pc   = sk_pc;
               new_inst = sk_inst;
               state_d  = ST_FETCH;
            end
         end
         ST_KILL: begin
            // The in-flight request must finish; only its data is dropped.
            if (branch_taken) tgt_d = branch_target;
            if (imem_ready) begin
               pc_d    = branch_taken ? branch_target : tgt_q;
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_BOOT;
      endcase

      if (branch_taken) begin
         valid_d = 1'b0;
      end else if (stall_n) begin
         if (new_v) begin
            valid_d = 1'b1;
            ipc_d   = new_pc;
            inst_d  = new_inst;
         end else begin
            valid_d = 1'b0;
         end
      end

      req_d = (state_d == ST_FETCH) || (state_d == ST_KILL);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         tgt_q   <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         ipc_q   <= '0;
         inst_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         req_q   <= req_d;
         valid_q <= valid_d;
         ipc_q   <= ipc_d;
         inst_q  <= inst_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign ifid_valid  = valid_q;
   assign ifid_pc     = ipc_q;
   assign ifid_inst   = inst_q;
   assign ifid_opcode = inst_q[OPCODE_HI:OPCODE_LO];
   assign ifid_rd     = inst_q[RD_HI:RD_LO];
   assign ifid_rs1    = inst_q[RS1_HI:RS1_LO];
   assign ifid_rs2    = inst_q[RS2_HI:RS2_LO];

endmodule

// File: tb/tb_fetch_stage_unit.sv
// Bench for fetch_stage_unit: directed vector table, async reset check and
// randomized traffic against a queue-based reference model.
module tb_fetch_stage_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        stall_n;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_ready;
   logic        ifid_valid;
   logic [15:0] ifid_pc;
   logic [15:0] ifid_inst;
   logic [3:0]  ifid_opcode, ifid_rd, ifid_rs1, ifid_rs2;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   fetch_stage_unit #(
      .PC_WIDTH   (16),
      .INST_WIDTH (16),
      .RESET_PC   (16'h0000)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .stall_n       (stall_n),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_ready    (imem_ready),
      .ifid_valid    (ifid_valid),
      .ifid_pc       (ifid_pc),
      .ifid_inst     (ifid_inst),
      .ifid_opcode   (ifid_opcode),
      .ifid_rd       (ifid_rd),
      .ifid_rs1      (ifid_rs1),
      .ifid_rs2      (ifid_rs2)
   );

   typedef struct packed {
      logic        st;
      logic        bt;
      logic [15:0] tgt;
      logic        rdy;
      logic [15:0] rd;
      logic        e_req;
      logic [15:0] e_addr;
      logic        e_v;
      logic [15:0] e_pc;
      logic [15:0] e_inst;
      logic        full;
   } vec_t;

   vec_t tab [17];

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic bt,
                        input logic [15:0] tgt, input logic rdy,
                        input logic [15:0] rd);
      stall_n       = st;
      branch_taken  = bt;
      branch_target = tgt;
      imem_ready    = rdy;
      imem_rdata    = rd;
   endtask

   // Checks outputs at a falling edge, then drives that row's inputs.
   task automatic run_row(input vec_t v, input int i);
      string tag;
      tag = $sformatf("row%0d", i);
      chk({tag, ".req"}, 16'(imem_req), 16'(v.e_req));
      chk({tag, ".addr"}, imem_addr, v.e_addr);
      chk({tag, ".valid"}, 16'(ifid_valid), 16'(v.e_v));
      if (v.e_v || v.full) begin
         chk({tag, ".pc"}, ifid_pc, v.e_pc);
         chk({tag, ".inst"}, ifid_inst, v.e_inst);
      end
      if (v.full) begin
         chk({tag, ".opc"}, 16'(ifid_opcode), 16'(v.e_inst[15:12]));
         chk({tag, ".rd"}, 16'(ifid_rd), 16'(v.e_inst[11:8]));
         chk({tag, ".rs1"}, 16'(ifid_rs1), 16'(v.e_inst[7:4]));
         chk({tag, ".rs2"}, 16'(ifid_rs2), 16'(v.e_inst[3:0]));
      end
      drive(v.st, v.bt, v.tgt, v.rdy, v.rd);
      @(negedge clock);
   endtask

   // Reference model: skid as a queue, pending redirect as a flag.
   logic        m_boot, m_kill, m_v;
   logic [15:0] m_pc, m_ktgt, m_ipc, m_inst;
   logic [31:0] m_skid [$];

   task automatic m_reset();
      m_boot = 1'b1;
      m_kill = 1'b0;
      m_v    = 1'b0;
      m_pc   = 16'h0000;
      m_ktgt = 16'h0000;
      m_ipc  = 16'h0000;
      m_inst = 16'h0000;
      m_skid.delete();
   endtask

   task automatic m_step(input logic st, input logic bt,
                         input logic [15:0] tgt, input logic rdy,
                         input logic [15:0] rd);
      bit          nl;
      logic [15:0] npc, ninst;
      nl    = 0;
      npc   = '0;
      ninst = '0;
      if (m_boot) begin
         m_boot = 1'b0;
      end else if (m_skid.size() != 0) begin
         if (bt) begin
            m_skid.delete();
            m_pc = tgt;
         end else if (st) begin
            {npc, ninst} = m_skid.pop_front();
            nl = 1;
         end
      end else if (m_kill) begin
         if (bt) m_ktgt = tgt;
         if (rdy) begin
            m_pc   = m_ktgt;
            m_kill = 1'b0;
         end
      end else if (bt) begin
         if (rdy) m_pc = tgt;
         else begin
            m_kill = 1'b1;
            m_ktgt = tgt;
         end
      end else if (rdy) begin
         if (st) begin
            nl    = 1;
            npc   = m_pc;
            ninst = rd;
         end else begin
            m_skid.push_back({m_pc, rd});
         end
         m_pc = m_pc + 16'd1;
      end
      if (bt) m_v = 1'b0;
      else if (st) begin
         if (nl) begin
            m_v    = 1'b1;
            m_ipc  = npc;
            m_inst = ninst;
         end else m_v = 1'b0;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      drive(1'b1, 1'b0, 16'h0, 1'b1, 16'h0);

      //         st    bt    tgt       rdy   rd         req   addr      v     pc        inst      full
      tab[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1};
      tab[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1};
      tab[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 16'h0001, 1'b1, 16'h0000, 16'h0000, 1'b1};
      tab[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h4123, 1'b1, 16'h0002, 1'b1, 16'h0001, 16'h0001, 1'b0};
      tab[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0003, 1'b1, 16'h0001, 16'h0001, 1'b0};
      tab[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0003, 1'b1, 16'h0001, 16'h0001, 1'b0};
      tab[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0003, 1'b1, 16'h0001, 16'h0001, 1'b0};
      tab[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 16'h0003, 1'b1, 16'h0002, 16'h4123, 1'b1};
      tab[8]  = '{1'b1, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0003, 16'h0003, 1'b0};
      tab[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000, 1'b0};
      tab[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hDEAD, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000, 1'b0};
      tab[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000, 1'b0};
      tab[12] = '{1'b0, 1'b1, 16'h0100, 1'b1, 16'h5555, 1'b1, 16'h0041, 1'b1, 16'h0040, 16'h1234, 1'b0};
      tab[13] = '{1'b1, 1'b1, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000, 1'b0};
      tab[14] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hABCD, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b0};
      tab[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0777, 1'b1, 16'h0000, 1'b1, 16'hFFFF, 16'hABCD, 1'b0};
      tab[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0001, 1'b1, 16'hFFFF, 16'hABCD, 1'b0};

      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 17; i++) run_row(tab[i], i);

      // Asynchronous reset while parked in HOLD.
      #2 reset_n = 1'b0;
      #1;
      chk("async.req", 16'(imem_req), 16'h0);
      chk("async.addr", imem_addr, 16'h0000);
      chk("async.valid", 16'(ifid_valid), 16'h0);
      chk("async.pc", ifid_pc, 16'h0000);
      chk("async.inst", ifid_inst, 16'h0000);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) run_row(tab[i], 100 + i);

      // Randomized traffic against the reference model.
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      m_reset();
      for (int c = 0; c < 3000; c++) begin
         logic        st, bt, rdy;
         logic [15:0] tgt, rd;
         chk("rnd.req", 16'(imem_req),
             16'(!m_boot && m_skid.size() == 0));
         chk("rnd.addr", imem_addr, m_pc);
         chk("rnd.valid", 16'(ifid_valid), 16'(m_v));
         if (m_v) begin
            chk("rnd.pc", ifid_pc, m_ipc);
            chk("rnd.inst", ifid_inst, m_inst);
            chk("rnd.opc", 16'(ifid_opcode), 16'(m_inst[15:12]));
         end
         st  = ($urandom_range(0, 4) != 0);
         bt  = ($urandom_range(0, 9) == 0);
         rdy = ($urandom_range(0, 9) < 7);
         rd  = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       tgt = 16'hFFFF;
            1:       tgt = 16'hFFFE;
            default: tgt = 16'($urandom);
         endcase
         drive(st, bt, tgt, rdy, rd);
         m_step(st, bt, tgt, rdy, rd);
         @(negedge clock);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
